mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the instruction-fetch requester and the data (load/store) requester of the rv32i pipeline. Only one transaction is in flight at a time. Data requests have priority. A starvation counter guarantees fetch progress during long load/store runs. The block sits between the pipeline's fetch/LSU front ends and the memory model, and its grant outputs act as the pipeline stall sources.

---
 rtl/cpu_mem_pkg.sv | 16 +
 rtl/mem_prio_arb.sv | 22 ++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the rv32i memory-port arbiter: FSM states, transaction owner
// and the byte-enable pattern used for instruction fetches.
package cpu_mem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Wide enough for any DATA_W up to 128; users slice off DATA_W/8 bits.
  localparam int unsigned          MAX_BE_W   = 16;
  localparam logic [MAX_BE_W-1:0]  IF_BE_FULL = '1;

endpackage

// File: rtl/mem_prio_arb.sv
// Combinational 2-way select: data wins unless fetch has waited out MAX_D_BURST data grants.
module mem_prio_arb #(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             grant_if,
  output logic             grant_d
);

  logic starved;

  assign starved = (burst_cnt >= CNT_W'(MAX_D_BURST));

  always_comb begin
    grant_if = if_req & (~d_req | starved);
    grant_d  = d_req & (~if_req | ~starved);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store, one transaction in flight,
// data priority with a starvation bound for fetch.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;

  logic [1:0]        state_q, state_d;
  logic              owner_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  burst_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              err_q;

  logic grant_if, grant_d;
  logic idle, accept, rsp_done;

  mem_prio_arb #(
    .MAX_D_BURST (MAX_D_BURST),
    .CNT_W       (CNT_W)
  ) u_prio_arb (
    .if_req    (if_req),
    .d_req     (d_req),
    .burst_cnt (burst_q),
    .grant_if  (grant_if),
    .grant_d   (grant_d)
  );

  assign idle     = (state_q == IDLE);
  assign accept   = idle & (grant_if | grant_d);
  assign rsp_done = (state_q == RSP) & mem_rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_gnt) state_d = RSP;
      RSP:     if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning request; fetches always read the full word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      if (grant_d) begin
        owner_q <= OWN_D;
        we_q    <= d_we;
        be_q    <= d_be;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else begin
        owner_q <= OWN_IF;
        we_q    <= 1'b0;
        be_q    <= IF_BE_FULL[BE_W-1:0];
        addr_q  <= if_addr;
        wdata_q <= '0;
      end
    end
  end

  // Counts data grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
    end else if (accept) begin
      if (grant_if) begin
        burst_q <= '0;
      end else if (if_req && (burst_q < CNT_W'(MAX_D_BURST))) begin
        burst_q <= burst_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= rsp_done & (owner_q == OWN_IF);
      d_rvalid_q  <= rsp_done & (owner_q == OWN_D);
      if (rsp_done) begin
        if (owner_q == OWN_D) begin
          d_rdata_q <= we_q ? '0 : mem_rdata;
        end else begin
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  // A response with nothing outstanding is a protocol violation; it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (mem_rvalid && (state_q != RSP)) begin
      err_q <= 1'b1;
    end
  end

  assign if_gnt    = idle & grant_if;
  assign d_gnt     = idle & grant_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

  // Requesters must hold their fields while waiting for a grant.
  if_stable_a : assert property (@(posedge clk) disable iff (rst)
    (if_req && $past(if_req && !if_gnt)) |-> (if_addr == $past(if_addr)));

  d_stable_a : assert property (@(posedge clk) disable iff (rst)
    (d_req && $past(d_req && !d_gnt)) |->
      ({d_we, d_be, d_addr, d_wdata} == $past({d_we, d_be, d_addr, d_wdata})));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants, memory-side
// requests and responses; independent monitors pop and compare.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_D_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    int          lat;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } mem_exp_t;

  rsp_exp_t rsp_q[$];
  mem_exp_t mem_q[$];
  logic     gnt_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gnt_count = 0;
  int gnt_cyc[2];
  bit mem_auto = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_if(input logic [31:0] addr, input logic [31:0] rdata,
                         input int delay, input int lat);
    gnt_q.push_back(1'b0);
    mem_q.push_back('{addr, 1'b0, 4'hF, 32'h0, delay, rdata});
    rsp_q.push_back('{1'b0, rdata, lat});
  endtask

  task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] mrdata,
                        input logic [31:0] exp_rdata, input int lat);
    gnt_q.push_back(1'b1);
    mem_q.push_back('{addr, we, be, wdata, delay, mrdata});
    rsp_q.push_back('{1'b1, exp_rdata, lat});
  endtask

  task automatic do_if(input logic [31:0] addr);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = addr;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = if_gnt;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL if_gnt_timeout: got no grant expected grant for %h", addr);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = d_gnt;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL d_gnt_timeout: got no grant expected grant for %h", addr);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (rsp_q.size() + mem_q.size() + gnt_q.size()) != 0; i++)
      @(negedge clk);
    check("drain", 32'(rsp_q.size() + mem_q.size() + gnt_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Grant monitor
  initial begin : gnt_mon
    logic e;
    forever begin
      @(negedge clk);
      if (if_gnt && d_gnt) begin
        tests++; fails++;
        $display("FAIL gnt_both: got both grants expected one");
      end else if (if_gnt || d_gnt) begin
        gnt_count++;
        gnt_cyc[int'(d_gnt)] = cyc;
        if (gnt_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL gnt_unexpected: got grant d=%0b expected none", d_gnt);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_order", {31'b0, d_gnt}, {31'b0, e});
        end
      end
    end
  end

  // Response monitor
  initial begin : rsp_mon
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid && d_rvalid) begin
        tests++; fails++;
        $display("FAIL rvalid_both: got both rvalid expected one");
      end else if (if_rvalid || d_rvalid) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: got rvalid d=%0b expected none", d_rvalid);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_owner", {31'b0, d_rvalid}, {31'b0, e.is_d});
          check("rsp_rdata", d_rvalid ? d_rdata : if_rdata, e.rdata);
          if (e.lat >= 0)
            check("rsp_latency", 32'(cyc - gnt_cyc[int'(e.is_d)]), 32'(e.lat));
        end
      end
    end
  end

  // Memory model: grants after the queued delay, answers one cycle later
  initial begin : mem_model
    mem_exp_t cur;
    int       wait_cnt;
    bit       active, rsp_next, stable_ok;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    active = 1'b0; rsp_next = 1'b0; stable_ok = 1'b1; wait_cnt = 0;
    cur = '{32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0};
    forever begin
      @(posedge clk); #1;
      if (!mem_auto || rst) begin
        active = 1'b0;
        rsp_next = 1'b0;
      end else begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (rsp_next) begin
          rsp_next = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata = cur.rdata;
          check("mem_req_drop", {31'b0, mem_req}, 32'd0);
        end else if (mem_req) begin
          if (!active) begin
            active = 1'b1;
            wait_cnt = 0;
            stable_ok = 1'b1;
            if (mem_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL mem_unexpected: got mem_req addr %h expected none", mem_addr);
              cur = '{mem_addr, mem_we, mem_be, mem_wdata, 0, 32'h0};
            end else begin
              cur = mem_q.pop_front();
            end
          end
          if (mem_addr !== cur.addr || mem_we !== cur.we || mem_be !== cur.be ||
              mem_wdata !== cur.wdata)
            stable_ok = 1'b0;
          if (wait_cnt == cur.delay) begin
            mem_gnt = 1'b1;
            rsp_next = 1'b1;
            active = 1'b0;
            check("mem_fields", {31'b0, stable_ok}, 32'd1);
          end else begin
            wait_cnt++;
          end
        end else if (active) begin
          active = 1'b0;
          tests++; fails++;
          $display("FAIL mem_req_held: got drop after %0d cycles expected %0d",
                   wait_cnt, cur.delay + 1);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch, fastest memory
    push_if(32'h10, 32'h0000_0013, 0, 3);
    do_if(32'h10);
    wait_drain();

    // Store with a slow memory grant; store ack returns zero data
    push_d(1'b1, 4'b0011, 32'h104, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 32'h0, 6);
    do_d(1'b1, 4'b0011, 32'h104, 32'hDEAD_BEEF);
    wait_drain();
    check("if_rdata_hold", if_rdata, 32'h0000_0013);
    check("d_store_rdata", d_rdata, 32'h0);

    // Both requesting continuously: four data grants then one fetch
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) push_if(32'h20, 32'h0000_0093, 0, -1);
      else push_d(1'b0, 4'hF, 32'h200, 32'h0, 0, 32'h0000_2200, 32'h0000_2200, -1);
    end
    begin
      int target;
      target = gnt_count + 10;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h0;
      for (int i = 0; i < 100 && gnt_count < target; i++) @(negedge clk);
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
    end
    wait_drain();
    check("burst_if_rdata", if_rdata, 32'h0000_0093);
    check("burst_d_rdata", d_rdata, 32'h0000_2200);
    check("err_clear", {31'b0, err}, 32'd0);

    // Load issued in the same cycle the previous fetch response pulses
    push_if(32'h40, 32'h0000_1111, 0, -1);
    push_d(1'b0, 4'hF, 32'h44, 32'h0, 0, 32'h0000_2222, 32'h0000_2222, -1);
    do_if(32'h40);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_rvalid;
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h44; d_wdata = 32'h0;
    @(negedge clk);
    check("b2b_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    check("b2b_d_gnt", {31'b0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("b2b_mem_req", {31'b0, mem_req}, 32'd1);
    check("b2b_mem_addr", mem_addr, 32'h44);
    wait_drain();

    // Stray mem_gnt is ignored; stray mem_rvalid sets a sticky error
    mem_auto = 1'b0;
    @(posedge clk); #1; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    check("stray_gnt_err", {31'b0, err}, 32'd0);
    check("stray_gnt_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rvalid_err", {31'b0, err}, 32'd1);
    mem_auto = 1'b1;
    push_if(32'h50, 32'h0000_0077, 0, -1);
    do_if(32'h50);
    wait_drain();
    check("err_sticky", {31'b0, err}, 32'd1);

    // Reset during RSP abandons the transaction; the late response is an error
    mem_auto = 1'b0;
    gnt_q.push_back(1'b1);
    do_d(1'b0, 4'hF, 32'h300, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    @(posedge clk); #1; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rsp_rst_err", {31'b0, err}, 32'd0);
    check("rsp_rst_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_err", {31'b0, err}, 32'd1);
    check("late_rvalid_d_rdata", d_rdata, 32'h0);
    repeat (3) @(negedge clk);
    check("idle_after_rst", {31'b0, mem_req}, 32'd0);
    mem_auto = 1'b1;
    push_if(32'h60, 32'h0000_ABCD, 0, 3);
    do_if(32'h60);
    wait_drain();
    check("err_after_txn", {31'b0, err}, 32'd1);

    check("queues_empty", 32'(rsp_q.size() + mem_q.size() + gnt_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
